instruction_fetch: RTL and testbench

//  Fetch stage feeding the ASIP Decoder. Drives the 16-bit `instruction` word that

---
 rtl/instruction_fetch.sv | 104 ++++++++++
 tb/tb_instruction_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage for the ASIP decoder: PC, 1-cycle synchronous imem read, registered output
// with a single-entry skid so a response landing during a stall is neither lost nor repeated.
module instruction_fetch #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  instr_pc
);

    // state | meaning
    // IDLE  | first clock out of reset, no reads issued
    // RUN   | streaming reads into the output register
    // HOLD  | stalled with a captured response waiting in the skid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  pc;
    logic               rd_pending;
    logic [ADDR_W-1:0]  pend_pc;
    logic               skid_full;
    logic [INSTR_W-1:0] skid_data;
    logic [ADDR_W-1:0]  skid_pc;

    assign imem_rd_en = fetch_en & ~stall & ~branch_taken & (state != IDLE);
    assign imem_addr  = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = RUN;
            RUN:     if (rd_pending && stall) state_next = HOLD;
            HOLD:    if (!stall) state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (branch_taken) state_next = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            rd_pending  <= 1'b0;
            pend_pc     <= '0;
            skid_full   <= 1'b0;
            skid_data   <= '0;
            skid_pc     <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
        end else if (branch_taken) begin
            // redirect discards both the skid and any response still in flight
            pc          <= branch_target;
            rd_pending  <= 1'b0;
            skid_full   <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            rd_pending <= imem_rd_en;
            if (imem_rd_en) begin
                pc      <= pc + ADDR_W'(1);
                pend_pc <= pc;
            end
            if (stall) begin
                if (rd_pending) begin
                    skid_full <= 1'b1;
                    skid_data <= imem_rdata;
                    skid_pc   <= pend_pc;
                end
            end else if (skid_full) begin
                instruction <= skid_data;
                instr_pc    <= skid_pc;
                instr_valid <= 1'b1;
                skid_full   <= 1'b0;
            end else if (rd_pending) begin
                instruction <= imem_rdata;
                instr_pc    <= pend_pc;
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic checked against an
// in-order delivery model (each word accepted by the decoder must be the next expected address).
module tb_instruction_fetch;

    localparam int AW = 16;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fetch_en = 1'b1;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic [IW-1:0] instruction;
    logic          instr_valid;
    logic [AW-1:0] instr_pc;

    int n_checks = 0;
    int n_pass = 0;

    instruction_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] p;
        if (a == 16'h0000) return 16'hF39D;
        if (a == 16'h0001) return 16'h5678;
        p = 32'(a) * 32'h9E37;
        return p[15:0] ^ 16'h1234;
    endfunction

    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // delivery model: decoder accepts a word whenever it is valid and not stalled
    logic [AW-1:0] exp_pc = '0;
    int            accepted = 0;
    logic          wrap_seen = 1'b0;
    logic [AW-1:0] last_acc_pc = '0;
    logic          prev_stall = 1'b0, prev_branch = 1'b0, prev_rst = 1'b1;
    logic [IW-1:0] prev_instr = '0;
    logic          prev_valid = 1'b0;
    logic [AW-1:0] prev_ipc = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc = '0;
        end else begin
            if (prev_stall && !prev_branch && !prev_rst) begin
                check("freeze_valid", 32'(instr_valid), 32'(prev_valid));
                check("freeze_pc", 32'(instr_pc), 32'(prev_ipc));
                check("freeze_instr", 32'(instruction), 32'(prev_instr));
            end
            if (stall || branch_taken || !fetch_en)
                check("rd_en_gate", 32'(imem_rd_en), 32'd0);
            if (instr_valid && !stall) begin
                check("seq_pc", 32'(instr_pc), 32'(exp_pc));
                check("seq_data", 32'(instruction), 32'(mem_word(exp_pc)));
                if (last_acc_pc == 16'hFFFF && instr_pc == 16'h0000) wrap_seen = 1'b1;
                last_acc_pc = instr_pc;
                exp_pc = exp_pc + 1'b1;
                accepted++;
            end
            if (branch_taken) exp_pc = branch_target;
        end
        prev_stall  = stall;
        prev_branch = branch_taken;
        prev_rst    = rst;
        prev_valid  = instr_valid;
        prev_ipc    = instr_pc;
        prev_instr  = instruction;
    end

    initial begin
        int found;
        int acc_start;
        #1 rst = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_ipc", 32'(instr_pc), 32'd0);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);

        // 1: first words after reset
        tick(); rst = 1'b0;
        tick(); #1;
        check("run_rd_en", 32'(imem_rd_en), 32'd1);
        check("run_addr", 32'(imem_addr), 32'd0);
        check("lat_bubble", 32'(instr_valid), 32'd0);
        tick(); #1;
        check("lat_bubble2", 32'(instr_valid), 32'd0);
        tick(); #1;
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_data", 32'(instruction), 32'hF39D);
        check("first_pc", 32'(instr_pc), 32'd0);
        tick(); #1;
        check("second_data", 32'(instruction), 32'h5678);
        check("second_pc", 32'(instr_pc), 32'd1);

        // 2: three-cycle stall mid-stream
        stall = 1'b1;
        repeat (3) begin
            tick(); #1;
            check("stall_hold_pc", 32'(instr_pc), 32'd1);
            check("stall_rd_en", 32'(imem_rd_en), 32'd0);
        end
        stall = 1'b0;
        tick(); #1;
        check("resume_pc", 32'(instr_pc), 32'd2);
        check("resume_data", 32'(instruction), 32'(mem_word(16'd2)));
        tick(); #1;
        check("resume_pc2", 32'(instr_pc), 32'd3);

        // 3: branch while stalled with the skid full
        stall = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0; stall = 1'b0; #1;
        check("br_bubble1", 32'(instr_valid), 32'd0);
        tick(); #1;
        check("br_bubble2", 32'(instr_valid), 32'd0);
        tick(); #1;
        check("br_valid", 32'(instr_valid), 32'd1);
        check("br_pc", 32'(instr_pc), 32'h40);
        check("br_data", 32'(instruction), 32'(mem_word(16'h40)));

        // 5: async reset while in HOLD
        stall = 1'b1;
        tick(); tick();
        rst = 1'b1; #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", 32'(instruction), 32'd0);
        check("arst_ipc", 32'(instr_pc), 32'd0);
        check("arst_rd_en", 32'(imem_rd_en), 32'd0);
        tick(); rst = 1'b0; stall = 1'b0;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            tick(); #1;
            if (instr_valid) found = 1;
        end
        check("arst_restart_seen", 32'(found), 32'd1);
        check("arst_first_pc", 32'(instr_pc), 32'd0);
        check("arst_first_data", 32'(instruction), 32'hF39D);
        repeat (3) tick();

        // 6: fetch_en dropped for four cycles
        fetch_en = 1'b0; #1;
        check("fe_rd_en", 32'(imem_rd_en), 32'd0);
        tick(); #1;
        check("fe_inflight", 32'(instr_valid), 32'd1);
        repeat (2) begin
            tick(); #1;
            check("fe_idle_valid", 32'(instr_valid), 32'd0);
            check("fe_idle_rd_en", 32'(imem_rd_en), 32'd0);
        end
        tick(); fetch_en = 1'b1;
        repeat (5) tick();

        // 4: address wrap
        branch_taken = 1'b1; branch_target = 16'hFFFD;
        tick(); branch_taken = 1'b0;
        repeat (10) tick();
        check("wrap_seen", 32'(wrap_seen), 32'd1);

        // randomized traffic
        acc_start = accepted;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) begin
                rst = 1'b0;
                branch_taken = 1'b0;
            end else if ($urandom_range(199) == 0) begin
                rst = 1'b1;
                branch_taken = 1'b0;
            end else begin
                stall = ($urandom_range(99) < 30);
                fetch_en = ($urandom_range(99) < 85);
                branch_taken = ($urandom_range(99) < 5);
                branch_target = ($urandom_range(3) == 0) ? AW'(16'hFFF8 + $urandom_range(7))
                                                         : AW'($urandom);
            end
        end
        tick();
        rst = 1'b0; branch_taken = 1'b0; stall = 1'b0; fetch_en = 1'b1;
        repeat (4) tick();
        check("rand_throughput", 32'(accepted - acc_start >= 300), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
